// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, instruction field slices and FSM encoding shared by the hazard controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    function automatic logic [1:0] op_of(input logic [7:0] instr);
        return instr[7:6];
    endfunction

    function automatic logic [2:0] rd_of(input logic [7:0] instr);
        return instr[5:3];
    endfunction

    function automatic logic [2:0] rs_of(input logic [7:0] instr);
        return instr[2:0];
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: shift register of in-flight destination registers; busy_regs covers every stage,
// including the one retiring this cycle, because the register file has no write-before-read.
module pipe_scoreboard #(
    parameter int NREG  = 8,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    output logic [NREG-1:0]         busy_regs,
    output logic                    empty
);

    localparam int RW = $clog2(NREG);

    logic [DEPTH-1:0] vld;
    logic [RW-1:0]    rd_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld[i]  <= vld[i-1];
                rd_q[i] <= rd_q[i-1];
            end
            vld[0]  <= issue_valid;
            rd_q[0] <= issue_rd;
        end
    end

    always_comb begin
        busy_regs = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) busy_regs[rd_q[i]] = 1'b1;
        empty = ~|vld;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decodes IF/ID, stalls on RAW hazards against the scoreboard and sequences
// the pipeline through fill / run / drain / halt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [7:0]       instr_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             bubble,
    output logic             WriteReg,
    output logic             SEtoReg,
    output logic             halted,
    output logic [NREG-1:0]  busy_regs,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int RW = $clog2(NREG);

    state_t     state, state_nxt;
    logic [1:0] op;
    logic [2:0] rd, rs;
    logic       hazard, issue, sb_empty;

    assign op = op_of(instr_id);
    assign rd = rd_of(instr_id);
    assign rs = rs_of(instr_id);

    // HALT and LI have no sources, so only ADD can hazard
    assign hazard = (state == S_RUN) && (op == OP_ADD) && (busy_regs[rd] || busy_regs[rs]);
    assign issue  = (state == S_RUN) && !hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   state_nxt = run ? S_FILL : S_IDLE;
            S_FILL:   state_nxt = S_RUN;
            S_RUN:    state_nxt = (!run || (issue && op == OP_HALT)) ? S_DRAIN : S_RUN;
            S_DRAIN:  state_nxt = sb_empty ? S_HALTED : S_DRAIN;
            S_HALTED: state_nxt = run ? S_HALTED : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_en      = (state == S_FILL) || issue;
        ifid_en    = (state == S_FILL) || issue;
        ifid_flush = (state == S_DRAIN);
        bubble     = (state == S_FILL) || (state == S_DRAIN) || hazard;
        WriteReg   = issue && (op == OP_LI || op == OP_ADD);
        SEtoReg    = issue && (op == OP_LI);
        halted     = (state == S_HALTED);
    end

    // a stall abandoned by run=0 is not counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 stall_cnt <= '0;
        else if (hazard && run && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    pipe_scoreboard #(.NREG(NREG), .DEPTH(DEPTH)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (WriteReg & ~bubble),
        .issue_rd    (rd[RW-1:0]),
        .busy_regs   (busy_regs),
        .empty       (sb_empty)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus against a per-register countdown model.
module tb_pipe_hazard_ctrl;

    localparam int DEPTH = 2;
    localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_DRAIN = 3, M_HALTED = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  instr_id = 8'h80;
    logic        pc_en, ifid_en, ifid_flush, bubble, WriteReg, SEtoReg, halted;
    logic [7:0]  busy_regs;
    logic [15:0] stall_cnt;
    logic        p2_pc_en, p2_ifid_en, p2_ifid_flush, p2_bubble, p2_wr, p2_se, p2_halted;
    logic [7:0]  p2_busy;
    logic [1:0]  p2_stall;

    int checks = 0;
    int failures = 0;

    int m_state = M_IDLE;
    int left [8];
    int m_stall = 0;

    logic        s_pc, s_ifen, s_flush, s_bub, s_wr, s_se, s_halt;
    logic [7:0]  s_busy;
    logic [15:0] s_stall;

    always #4 clk = ~clk;

    pipe_hazard_ctrl #(.NREG(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_id(instr_id),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .bubble(bubble),
        .WriteReg(WriteReg), .SEtoReg(SEtoReg), .halted(halted),
        .busy_regs(busy_regs), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.NREG(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .run(run), .instr_id(instr_id),
        .pc_en(p2_pc_en), .ifid_en(p2_ifid_en), .ifid_flush(p2_ifid_flush), .bubble(p2_bubble),
        .WriteReg(p2_wr), .SEtoReg(p2_se), .halted(p2_halted),
        .busy_regs(p2_busy), .stall_cnt(p2_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_stall = 0;
        for (int r = 0; r < 8; r++) left[r] = 0;
    endtask

    // drive now, check combinational outputs 1 unit later, then advance model across the next edge
    task automatic step_now(input logic r_in, input logic [7:0] ins);
        int op, rd, rs;
        logic [7:0] mb;
        logic haz, e_pc, e_bub, e_wr, e_se;
        run = r_in;
        instr_id = ins;
        #1;
        op = int'(ins[7:6]);
        rd = int'(ins[5:3]);
        rs = int'(ins[2:0]);
        mb = '0;
        for (int r = 0; r < 8; r++) if (left[r] > 0) mb[r] = 1'b1;
        haz   = (m_state == M_RUN) && (op == 1) && (mb[rd] || mb[rs]);
        e_pc  = (m_state == M_FILL) || (m_state == M_RUN && !haz);
        e_bub = (m_state == M_FILL) || (m_state == M_DRAIN) || haz;
        e_wr  = (m_state == M_RUN) && !haz && op < 2;
        e_se  = (m_state == M_RUN) && !haz && op == 0;
        s_pc = pc_en; s_ifen = ifid_en; s_flush = ifid_flush; s_bub = bubble;
        s_wr = WriteReg; s_se = SEtoReg; s_halt = halted; s_busy = busy_regs; s_stall = stall_cnt;
        chk("pc_en", s_pc, e_pc);
        chk("ifid_en", s_ifen, e_pc);
        chk("ifid_flush", s_flush, m_state == M_DRAIN);
        chk("bubble", s_bub, e_bub);
        chk("WriteReg", s_wr, e_wr);
        chk("SEtoReg", s_se, e_se);
        chk("halted", s_halt, m_state == M_HALTED);
        chk("busy_regs", s_busy, mb);
        chk("stall_cnt", s_stall, m_stall);
        chk("stall_cnt_sat", p2_stall, m_stall > 3 ? 3 : m_stall);
        @(posedge clk);
        for (int r = 0; r < 8; r++) if (left[r] > 0) left[r]--;
        if (e_wr) left[rd] = DEPTH;
        if (haz && r_in && m_stall < 65535) m_stall++;
        case (m_state)
            M_IDLE:   m_state = r_in ? M_FILL : M_IDLE;
            M_FILL:   m_state = M_RUN;
            M_RUN:    m_state = (!r_in || (!haz && op == 3)) ? M_DRAIN : M_RUN;
            M_DRAIN:  m_state = (mb == 0) ? M_HALTED : M_DRAIN;
            default:  m_state = r_in ? M_HALTED : M_IDLE;
        endcase
    endtask

    task automatic step(input logic r_in, input logic [7:0] ins);
        @(negedge clk);
        step_now(r_in, ins);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc_en"}, pc_en, 1'b0);
        chk({tag, "_ifid_en"}, ifid_en, 1'b0);
        chk({tag, "_flush"}, ifid_flush, 1'b0);
        chk({tag, "_bubble"}, bubble, 1'b0);
        chk({tag, "_wr"}, {WriteReg, SEtoReg}, 2'b00);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_busy"}, busy_regs, 8'h00);
        chk({tag, "_stall"}, stall_cnt, 16'h0);
    endtask

    initial begin
        int base;
        model_reset();
        #1;
        check_reset_state("rst0");
        reset = 1'b0;
        step_now(1'b1, 8'h80);
        step(1'b1, 8'b00_001_110);
        // now in RUN with LI r1 about to issue; pulse reset at t=13
        run = 1'b1;
        instr_id = 8'b00_001_110;
        #1;
        chk("pre_rst_run_pc_en", pc_en, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_state("rst_mid_run");
        model_reset();
        #1;
        reset = 1'b0;

        // LI r1 then LI r2
        step(1'b1, 8'h80);
        step(1'b1, 8'h80);
        step(1'b1, 8'b00_001_110);
        chk("t2_li1_ctrl", {s_bub, s_wr, s_se}, 3'b011);
        step(1'b1, 8'b00_010_010);
        chk("t2_busy_a", s_busy, 8'h02);
        chk("t2_li2_ctrl", {s_bub, s_wr, s_se}, 3'b011);
        step(1'b1, 8'h80);
        chk("t2_busy_b", s_busy, 8'h06);
        step(1'b1, 8'h80);
        step(1'b1, 8'h80);

        // LI r1 then ADD r1,r2: two stall cycles
        base = m_stall;
        step(1'b1, 8'b00_001_110);
        step(1'b1, 8'b01_001_010);
        chk("t3_stall1", {s_bub, s_pc, s_ifen}, 3'b100);
        step(1'b1, 8'b01_001_010);
        chk("t3_stall2", {s_bub, s_pc, s_ifen}, 3'b100);
        step(1'b1, 8'b01_001_010);
        chk("t3_issue", {s_bub, s_wr, s_se}, 3'b010);
        chk("t3_stall_cnt", s_stall, 16'(base + 2));
        step(1'b1, 8'h80);
        step(1'b1, 8'h80);

        // LI r3 then HALT: drain until scoreboard empty
        step(1'b1, 8'b00_011_001);
        step(1'b1, 8'b11_000_000);
        chk("t4_halt_issues", {s_pc, s_bub, s_wr}, 3'b100);
        step(1'b1, 8'h80);
        chk("t4_drain1", {s_flush, s_bub, s_pc}, 3'b110);
        chk("t4_drain1_busy", s_busy, 8'h08);
        step(1'b1, 8'h80);
        chk("t4_drain2", {s_flush, s_busy}, {1'b1, 8'h00});
        step(1'b1, 8'h80);
        chk("t4_halted", s_halt, 1'b1);
        step(1'b0, 8'h80);
        step(1'b0, 8'h80);
        chk("t4_idle", {s_halt, s_pc, s_bub}, 3'b000);

        // repeated stalls push the 2-bit counter into saturation
        step(1'b1, 8'h80);
        step(1'b1, 8'h80);
        step(1'b1, 8'b00_001_001);
        for (int k = 0; k < 6; k++) step(1'b1, 8'b01_001_001);
        step(1'b1, 8'h80);
        chk("t5_sat", p2_stall, 2'b11);
        step(1'b1, 8'h80);
        step(1'b1, 8'h80);

        // run=0 during a stall: drain next, no count; then reset while draining
        step(1'b1, 8'b00_100_011);
        base = m_stall;
        step(1'b0, 8'b01_100_100);
        chk("t6_stall_seen", s_bub, 1'b1);
        step(1'b0, 8'h80);
        chk("t6_drain", s_flush, 1'b1);
        chk("t6_no_incr", s_stall, 16'(base));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", busy_regs, 8'h00);
        chk("t6_rst_flush", ifid_flush, 1'b0);
        chk("t6_rst_stall", stall_cnt, 16'h0);
        model_reset();
        #1;
        reset = 1'b0;

        for (int n = 0; n < 500; n++) begin
            logic r_in;
            logic [7:0] ins;
            ins = {2'($urandom_range(0, 3)), 1'b0, 2'($urandom_range(0, 3)), 1'b0, 2'($urandom_range(0, 3))};
            if (ins[7:6] == 2'b11 && $urandom_range(0, 3) != 0) ins[7:6] = 2'b01;
            r_in = (m_state == M_HALTED) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) != 0);
            step(r_in, ins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
